data_cache: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache between the execute/memory pipeline stage and the data memory.
- Presents the same load/store interface the pipeline already uses: word/byte access with sign select.
- Forwards misses and all stores to the backing memory over a req/ready handshake.
- Raises stall_o while the pipeline must hold its request stable.

---
 rtl/data_cache_pkg.sv | 14 +
 rtl/data_cache_array.sv | 66 ++++++
 rtl/data_cache.sv | 163 ++++++++++++++++
 tb/tb_data_cache.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_cache_pkg.sv
// Shared types and constants for the data cache slice.
package data_cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } cache_state_t;

  localparam logic MEM_WORD = 1'b0;
  localparam logic MEM_BYTE = 1'b1;

endpackage

// File: rtl/data_cache_array.sv
// Valid/tag/data storage for a direct-mapped cache with one-word lines.
// Read is combinational by index; writes land on the rising edge with
// per-byte-lane enables. Only the valid bits are reset.
module data_cache_array #(
  parameter int unsigned SETS       = 64,
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned TAG_BITS   = 24,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [INDEX_BITS-1:0]   rd_index_i,
  output logic                    rd_valid_o,
  output logic [TAG_BITS-1:0]     rd_tag_o,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  input  logic                    wr_en_i,
  input  logic [INDEX_BITS-1:0]   wr_index_i,
  input  logic [TAG_BITS-1:0]     wr_tag_i,
  input  logic [DATA_WIDTH/8-1:0] wr_byte_en_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i
);

  localparam int unsigned LANES = DATA_WIDTH / 8;

  logic [SETS-1:0]       valid_q, valid_d;
  logic [TAG_BITS-1:0]   tag_q  [SETS];
  logic [TAG_BITS-1:0]   tag_d  [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS];
  logic [DATA_WIDTH-1:0] data_d [SETS];

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i];

  // Next array contents: a write marks the line valid, sets its tag and merges enabled lanes.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en_i) begin
      valid_d[wr_index_i] = 1'b1;
      tag_d[wr_index_i]   = wr_tag_i;
      for (int unsigned b = 0; b < LANES; b++) begin
        if (wr_byte_en_i[b]) begin
          data_d[wr_index_i][8*b +: 8] = wr_data_i[8*b +: 8];
        end
      end
    end
  end

  // Valid bits clear on reset so the whole cache misses afterwards.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data storage carry no reset.
  always_ff @(posedge clk_i) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache sitting between
// the pipeline load/store port and the backing data memory.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned SETS          = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_valid_i,
  input  logic                     write_enable_i,
  input  logic [ADDRESS_WIDTH-1:0] address_i,
  input  logic [DATA_WIDTH-1:0]    write_data_i,
  input  logic                     mem_type_i,
  input  logic                     mem_sign_i,
  output logic [DATA_WIDTH-1:0]    read_value_o,
  output logic                     stall_o,
  output logic                     mem_req_o,
  output logic                     mem_write_o,
  output logic [ADDRESS_WIDTH-1:0] mem_address_o,
  output logic                     mem_type_o,
  output logic [DATA_WIDTH-1:0]    mem_write_data_o,
  input  logic                     mem_ready_i,
  input  logic [DATA_WIDTH-1:0]    mem_read_data_i
);

  localparam int unsigned INDEX_BITS = $clog2(SETS);
  localparam int unsigned TAG_BITS   = ADDRESS_WIDTH - 2 - INDEX_BITS;
  localparam int unsigned LANES      = DATA_WIDTH / 8;

  cache_state_t state_q, state_d;

  logic [1:0]            offset;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic                  line_valid;
  logic [TAG_BITS-1:0]   line_tag;
  logic [DATA_WIDTH-1:0] line_data;
  logic                  hit;

  logic                  wr_en;
  logic [LANES-1:0]      wr_byte_en;
  logic [DATA_WIDTH-1:0] wr_data;

  int unsigned           lane_idx;
  logic [7:0]            lane_byte;
  logic [DATA_WIDTH-1:0] load_value;
  logic [LANES-1:0]      store_byte_en;
  logic [DATA_WIDTH-1:0] store_data;

  assign offset = address_i[1:0];
  assign index  = address_i[INDEX_BITS+1:2];
  assign tag    = address_i[ADDRESS_WIDTH-1 -: TAG_BITS];
  assign hit    = line_valid && (line_tag == tag);

  assign mem_write_data_o = write_data_i;

  data_cache_array #(
    .SETS       (SETS),
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rd_index_i   (index),
    .rd_valid_o   (line_valid),
    .rd_tag_o     (line_tag),
    .rd_data_o    (line_data),
    .wr_en_i      (wr_en),
    .wr_index_i   (index),
    .wr_tag_i     (tag),
    .wr_byte_en_i (wr_byte_en),
    .wr_data_i    (wr_data)
  );

  // Big-endian lane selection and load extension; also the store merge pattern.
  always_comb begin
    lane_idx  = LANES - 1 - 32'(offset);
    lane_byte = 8'(line_data >> (8 * lane_idx));
    if (mem_type_i == MEM_BYTE) begin
      load_value    = mem_sign_i ? {{(DATA_WIDTH-8){lane_byte[7]}}, lane_byte}
                                 : {{(DATA_WIDTH-8){1'b0}}, lane_byte};
      store_byte_en = {{(LANES-1){1'b0}}, 1'b1} << lane_idx;
      store_data    = {LANES{write_data_i[7:0]}};
    end else begin
      load_value    = line_data;
      store_byte_en = '1;
      store_data    = write_data_i;
    end
  end

  // Controller state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, pipeline/backing handshake outputs and array write control.
  always_comb begin
    state_d       = state_q;
    stall_o       = 1'b0;
    read_value_o  = '0;
    mem_req_o     = 1'b0;
    mem_write_o   = 1'b0;
    mem_address_o = '0;
    mem_type_o    = MEM_WORD;
    wr_en         = 1'b0;
    wr_byte_en    = '1;
    wr_data       = mem_read_data_i;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (write_enable_i) begin
            stall_o = 1'b1;
            state_d = WRITE;
          end else if (hit) begin
            read_value_o = load_value;
          end else begin
            stall_o = 1'b1;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        // Runs to completion even if the pipeline flushes its request.
        stall_o       = 1'b1;
        mem_req_o     = 1'b1;
        mem_address_o = {address_i[ADDRESS_WIDTH-1:2], 2'b00};
        if (mem_ready_i) begin
          wr_en   = 1'b1;
          state_d = IDLE;
        end
      end
      WRITE: begin
        stall_o       = 1'b1;
        mem_req_o     = 1'b1;
        mem_write_o   = 1'b1;
        mem_address_o = address_i;
        mem_type_o    = mem_type_i;
        if (mem_ready_i) begin
          // Resident lines are kept coherent; misses are not allocated.
          wr_en      = hit;
          wr_byte_en = store_byte_en;
          wr_data    = store_data;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios plus a randomized
// mix checked against a residency model and a backing-memory model.
module tb_data_cache;

  localparam int unsigned SETS = 64;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_valid;
  logic        write_enable;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        mem_type;
  logic        mem_sign;
  logic [31:0] read_value_o;
  logic        stall_o;
  logic        mem_req_o;
  logic        mem_write_o;
  logic [31:0] mem_address_o;
  logic        mem_type_o;
  logic [31:0] mem_write_data_o;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  data_cache #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .SETS          (SETS)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .req_valid_i      (req_valid),
    .write_enable_i   (write_enable),
    .address_i        (address),
    .write_data_i     (write_data),
    .mem_type_i       (mem_type),
    .mem_sign_i       (mem_sign),
    .read_value_o     (read_value_o),
    .stall_o          (stall_o),
    .mem_req_o        (mem_req_o),
    .mem_write_o      (mem_write_o),
    .mem_address_o    (mem_address_o),
    .mem_type_o       (mem_type_o),
    .mem_write_data_o (mem_write_data_o),
    .mem_ready_i      (mem_ready),
    .mem_read_data_i  (mem_rdata)
  );

  int total = 0;
  int bad   = 0;

  // Backing memory, word-addressed; unseen words get random contents.
  logic [31:0] bmem [int unsigned];
  // Which word address (if any) each set currently holds.
  bit          mdl_valid [SETS];
  logic [29:0] mdl_word  [SETS];

  // Observations from the most recent access.
  int          obs_stalls;
  int          obs_reqs;
  logic [31:0] obs_rv;
  logic [31:0] obs_addr;
  logic        obs_write;
  logic        obs_type;
  logic [31:0] obs_wdata;

  function automatic logic [31:0] bget(input logic [31:0] a);
    int unsigned k = int'(a >> 2);
    if (!bmem.exists(k)) bmem[k] = $urandom;
    return bmem[k];
  endfunction

  function automatic void bput(input logic [31:0] a, input logic [31:0] wd, input bit mt);
    logic [31:0] w;
    int unsigned sh;
    w = bget(a);
    if (mt) begin
      sh = 8 * (3 - int'(a[1:0]));
      w  = (w & ~(32'hFF << sh)) | ({24'b0, wd[7:0]} << sh);
    end else begin
      w = wd;
    end
    bmem[int'(a >> 2)] = w;
  endfunction

  function automatic logic [31:0] expect_load(input logic [31:0] a, input bit mt, input bit ms);
    logic [31:0] w;
    logic [7:0]  b;
    w = bget(a);
    if (!mt) return w;
    b = 8'(w >> (8 * (3 - int'(a[1:0]))));
    return ms ? {{24{b[7]}}, b} : {24'b0, b};
  endfunction

  // Returns whether the access hits, then applies its residency effect.
  function automatic bit mdl_step(input bit we, input logic [31:0] a);
    int unsigned idx = int'(a[7:2]);
    bit h = mdl_valid[idx] && (mdl_word[idx] == a[31:2]);
    if (!we && !h) begin
      mdl_valid[idx] = 1'b1;
      mdl_word[idx]  = a[31:2];
    end
    return h;
  endfunction

  function automatic void mdl_clear();
    for (int i = 0; i < int'(SETS); i++) mdl_valid[i] = 1'b0;
  endfunction

  // Drives one pipeline access and acts as backing memory, answering on the d-th request cycle.
  task automatic run_access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                            input bit mt, input bit ms, input int d);
    req_valid    = 1'b1;
    write_enable = we;
    address      = a;
    write_data   = wd;
    mem_type     = mt;
    mem_sign     = ms;
    obs_stalls   = 0;
    obs_reqs     = 0;
    obs_rv       = 32'hxxxx_xxxx;
    obs_addr     = '0;
    obs_write    = 1'b0;
    obs_type     = 1'b0;
    obs_wdata    = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (!stall_o) begin
        obs_rv = read_value_o;
        break;
      end
      obs_stalls++;
      mem_ready = 1'b0;
      if (mem_req_o) begin
        obs_reqs++;
        obs_addr  = mem_address_o;
        obs_write = mem_write_o;
        obs_type  = mem_type_o;
        obs_wdata = mem_write_data_o;
        if (obs_reqs == d) begin
          mem_ready = 1'b1;
          if (we) bput(a, wd, mt);
          else    mem_rdata = bget(a);
        end
      end
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      mem_rdata = $urandom;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    req_valid = 1'b0; write_enable = 1'b0; address = '0; write_data = '0;
    mem_type = 1'b0; mem_sign = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    mdl_clear();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    total++; if (stall_o !== 1'b0)  begin bad++; $display("FAIL reset_stall: got %b want 0", stall_o); end
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL reset_mem_req: got %b want 0", mem_req_o); end
    total++; if (mem_write_o !== 1'b0) begin bad++; $display("FAIL reset_mem_write: got %b want 0", mem_write_o); end
    total++; if (read_value_o !== 32'h0) begin bad++; $display("FAIL reset_read_value: got %h want 0", read_value_o); end
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_fill_hit();
    bmem[32'h100 >> 2] = 32'hDEAD_BEEF;
    void'(mdl_step(1'b0, 32'h100));
    run_access(1'b0, 32'h100, '0, 1'b0, 1'b0, 3);
    total++; if (obs_stalls !== 4) begin bad++; $display("FAIL fill_stalls: got %0d want 4", obs_stalls); end
    total++; if (obs_rv !== 32'hDEAD_BEEF) begin bad++; $display("FAIL fill_value: got %h want deadbeef", obs_rv); end
    total++; if (obs_addr !== 32'h100 || obs_write !== 1'b0 || obs_type !== 1'b0) begin
      bad++; $display("FAIL fill_req: got addr=%h wr=%b type=%b want 100/0/0", obs_addr, obs_write, obs_type); end
    void'(mdl_step(1'b0, 32'h100));
    run_access(1'b0, 32'h100, '0, 1'b0, 1'b0, 1);
    total++; if (obs_stalls !== 0 || obs_reqs !== 0) begin
      bad++; $display("FAIL repeat_hit: got stalls=%0d reqs=%0d want 0/0", obs_stalls, obs_reqs); end
    total++; if (obs_rv !== 32'hDEAD_BEEF) begin bad++; $display("FAIL repeat_value: got %h want deadbeef", obs_rv); end
  endtask

  task automatic test_byte_loads();
    logic [31:0] addrs [4] = '{32'h100, 32'h103, 32'h100, 32'h103};
    bit          signs [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] wants [4] = '{32'hFFFF_FFDE, 32'hFFFF_FFEF, 32'h0000_00DE, 32'h0000_00EF};
    for (int i = 0; i < 4; i++) begin
      run_access(1'b0, addrs[i], '0, 1'b1, signs[i], 1);
      total++; if (obs_stalls !== 0 || obs_rv !== wants[i]) begin
        bad++; $display("FAIL byte_load[%0d]: got stalls=%0d value=%h want 0/%h", i, obs_stalls, obs_rv, wants[i]); end
    end
  endtask

  task automatic test_byte_store();
    void'(mdl_step(1'b1, 32'h101));
    run_access(1'b1, 32'h101, 32'hAAAA_AA55, 1'b1, 1'b0, 1);
    total++; if (obs_stalls !== 2) begin bad++; $display("FAIL bstore_stalls: got %0d want 2", obs_stalls); end
    total++; if (obs_addr !== 32'h101 || obs_write !== 1'b1 || obs_type !== 1'b1) begin
      bad++; $display("FAIL bstore_req: got addr=%h wr=%b type=%b want 101/1/1", obs_addr, obs_write, obs_type); end
    total++; if (obs_wdata !== 32'hAAAA_AA55) begin bad++; $display("FAIL bstore_wdata: got %h want aaaaaa55", obs_wdata); end
    total++; if (obs_rv !== 32'h0) begin bad++; $display("FAIL bstore_done_value: got %h want 0", obs_rv); end
    @(negedge clk);
    total++; if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin
      bad++; $display("FAIL bstore_no_reissue: got req=%b stall=%b want 0/0", mem_req_o, stall_o); end
    @(posedge clk);
    #1;
    run_access(1'b0, 32'h100, '0, 1'b0, 1'b0, 1);
    total++; if (obs_stalls !== 0 || obs_rv !== 32'hDE55_BEEF) begin
      bad++; $display("FAIL bstore_merge: got stalls=%0d value=%h want 0/de55beef", obs_stalls, obs_rv); end
  endtask

  task automatic test_store_miss();
    void'(mdl_step(1'b1, 32'h2000));
    run_access(1'b1, 32'h2000, 32'h1234_5678, 1'b0, 1'b0, 2);
    total++; if (obs_stalls !== 3 || obs_addr !== 32'h2000 || obs_type !== 1'b0) begin
      bad++; $display("FAIL smiss_req: got stalls=%0d addr=%h type=%b want 3/2000/0", obs_stalls, obs_addr, obs_type); end
    void'(mdl_step(1'b0, 32'h100));
    run_access(1'b0, 32'h100, '0, 1'b0, 1'b0, 1);
    total++; if (obs_stalls !== 0 || obs_rv !== 32'hDE55_BEEF) begin
      bad++; $display("FAIL smiss_no_alloc: got stalls=%0d value=%h want 0/de55beef", obs_stalls, obs_rv); end
    void'(mdl_step(1'b0, 32'h2000));
    run_access(1'b0, 32'h2000, '0, 1'b0, 1'b0, 1);
    total++; if (obs_stalls !== 2 || obs_addr !== 32'h2000 || obs_rv !== 32'h1234_5678) begin
      bad++; $display("FAIL smiss_reload: got stalls=%0d addr=%h value=%h want 2/2000/12345678", obs_stalls, obs_addr, obs_rv); end
  endtask

  task automatic test_conflict();
    logic [31:0] seq [3] = '{32'h100, 32'h100 + 4 * SETS, 32'h100};
    for (int i = 0; i < 3; i++) begin
      void'(mdl_step(1'b0, seq[i]));
      run_access(1'b0, seq[i], '0, 1'b0, 1'b0, 1);
      total++; if (obs_stalls !== 2 || obs_addr !== seq[i] || obs_rv !== bget(seq[i])) begin
        bad++; $display("FAIL conflict[%0d]: got stalls=%0d addr=%h value=%h want 2/%h/%h",
                        i, obs_stalls, obs_addr, obs_rv, seq[i], bget(seq[i])); end
    end
  endtask

  task automatic test_flush();
    req_valid = 1'b1; write_enable = 1'b0; address = 32'h3F0; mem_type = 1'b0; mem_sign = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    total++; if (mem_req_o !== 1'b1 || mem_address_o !== 32'h3F0) begin
      bad++; $display("FAIL flush_req_held: got req=%b addr=%h want 1/3f0", mem_req_o, mem_address_o); end
    mem_ready = 1'b1;
    mem_rdata = bget(32'h3F0);
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    @(negedge clk);
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL flush_req_drop: got %b want 0", mem_req_o); end
    @(posedge clk);
    #1;
    void'(mdl_step(1'b0, 32'h3F0));
    run_access(1'b0, 32'h3F0, '0, 1'b0, 1'b0, 1);
    total++; if (obs_stalls !== 0 || obs_rv !== bget(32'h3F0)) begin
      bad++; $display("FAIL flush_installed: got stalls=%0d value=%h want 0/%h", obs_stalls, obs_rv, bget(32'h3F0)); end
  endtask

  task automatic test_reset_mid_fill();
    req_valid = 1'b1; write_enable = 1'b0; address = 32'h504; mem_type = 1'b0; mem_sign = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL rst_fill_entered: got %b want 1", mem_req_o); end
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    total++; if (mem_req_o !== 1'b0 || stall_o !== 1'b0 || mem_write_o !== 1'b0 || read_value_o !== 32'h0) begin
      bad++; $display("FAIL rst_outputs: got req=%b stall=%b wr=%b value=%h want 0/0/0/0",
                      mem_req_o, stall_o, mem_write_o, read_value_o); end
    mem_ready = 1'b1;
    mem_rdata = $urandom;
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    rst_ni = 1'b1;
    @(negedge clk);
    total++; if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin
      bad++; $display("FAIL rst_ready_ignored: got req=%b stall=%b want 0/0", mem_req_o, stall_o); end
    @(posedge clk);
    #1;
    mdl_clear();
    void'(mdl_step(1'b0, 32'h100));
    run_access(1'b0, 32'h100, '0, 1'b0, 1'b0, 1);
    total++; if (obs_stalls !== 2 || obs_rv !== bget(32'h100)) begin
      bad++; $display("FAIL rst_valid_cleared: got stalls=%0d value=%h want 2/%h", obs_stalls, obs_rv, bget(32'h100)); end
    void'(mdl_step(1'b0, 32'h504));
    run_access(1'b0, 32'h504, '0, 1'b0, 1'b0, 1);
    total++; if (obs_stalls !== 2) begin bad++; $display("FAIL rst_fill_dropped: got stalls=%0d want 2", obs_stalls); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a, wd, exp_v;
      bit we, mt, ms, h;
      int d, exp_stalls;
      a  = 32'h1000 + 32'($urandom_range(0, 2)) * 256 + 32'($urandom_range(0, 3)) * 4
           + 32'($urandom_range(0, 3));
      we = ($urandom_range(0, 2) == 0);
      mt = 1'($urandom_range(0, 1));
      ms = 1'($urandom_range(0, 1));
      wd = $urandom;
      d  = int'($urandom_range(1, 3));
      exp_v = we ? 32'h0 : expect_load(a, mt, ms);
      h = mdl_step(we, a);
      exp_stalls = (!we && h) ? 0 : d + 1;
      run_access(we, a, wd, mt, ms, d);
      total++; if (obs_stalls !== exp_stalls || obs_rv !== exp_v) begin
        bad++; $display("FAIL rand[%0d] we=%b a=%h: got stalls=%0d value=%h want %0d/%h",
                        n, we, a, obs_stalls, obs_rv, exp_stalls, exp_v); end
      if (we) begin
        total++; if (obs_addr !== a || obs_write !== 1'b1 || obs_type !== mt || obs_wdata !== wd) begin
          bad++; $display("FAIL rand_store[%0d]: got addr=%h wr=%b type=%b data=%h want %h/1/%b/%h",
                          n, obs_addr, obs_write, obs_type, obs_wdata, a, mt, wd); end
      end else if (!h) begin
        total++; if (obs_addr !== {a[31:2], 2'b00} || obs_write !== 1'b0 || obs_type !== 1'b0) begin
          bad++; $display("FAIL rand_fill[%0d]: got addr=%h wr=%b type=%b want %h/0/0",
                          n, obs_addr, obs_write, obs_type, {a[31:2], 2'b00}); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_hit();
    test_byte_loads();
    test_byte_store();
    test_store_miss();
    test_conflict();
    test_flush();
    test_reset_mid_fill();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
